sseg_frame_decode: RTL and testbench

Receive-side decoder for the multiplexed four-digit seven-segment bus (`ssegs`/`disp_en`) produced by the display driver. It qualifies each digit strobe, decodes segment patterns back to digit codes, and assembles one complete four-position frame. It then converts the frame to a 14-bit binary value and presents it on a valid/ready output. It sits on the bench and self-check side of the board design, looping the display outputs back for readback and verification.

---
 rtl/sseg_pkg.sv | 36 +++
 rtl/sseg_char_dec.sv | 37 +++
 rtl/sseg_frame_decode.sv | 155 +++++++++++++++
 tb/tb_sseg_frame_decode.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants, state encoding and helpers for the seven-segment frame decoder.
package sseg_pkg;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_DASH  = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [3:0] EN_POS3 = 4'b1110;
    localparam logic [3:0] EN_POS2 = 4'b1101;
    localparam logic [3:0] EN_POS1 = 4'b1011;
    localparam logic [3:0] EN_POS0 = 4'b0111;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        HOLD
    } state_t;

    // Dash, blank and illegal positions all contribute zero to the binary value.
    function automatic logic [13:0] digit_weight(input logic [3:0] code);
        return (code <= 4'd9) ? {10'd0, code} : 14'd0;
    endfunction

endpackage

// File: rtl/sseg_char_dec.sv
// Combinational decode of one active-low segment pattern into a digit code, illegal flag and dp.
module sseg_char_dec
    import sseg_pkg::*;
(
    input  logic [7:0] ssegs,
    output logic [3:0] code,
    output logic       illegal,
    output logic       dp
);

    logic [7:0] pattern;

    // The dp bit is forced off so the decimal point never changes the character.
    assign pattern = {ssegs[7:1], 1'b1};
    assign dp      = ~ssegs[0];

    always_comb begin
        code    = CODE_BLANK;
        illegal = 1'b0;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_DASH:  code = CODE_DASH;
            SEG_BLANK: code = CODE_BLANK;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_frame_decode.sv
// Reassembles a four-digit frame from the multiplexed display bus and converts it to binary.
// Optional SSEG_DEC_DROP_CNT_EN adds drop_cnt, counting frames lost while the output is held.
module sseg_frame_decode
    import sseg_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ssegs,
    input  logic [3:0]  disp_en,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [13:0] value,
    output logic [15:0] digits,
    output logic        neg,
    output logic        no_data,
    output logic        dp_en,
    output logic [1:0]  dp_sel,
    output logic        err
`ifdef SSEG_DEC_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);

    localparam logic [7:0] SETTLE_CNT  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t      state, state_next;
    logic [3:0]  prev_en;
    logic [7:0]  stable_cnt, cnt_eff;
    logic        pos_valid, capture, frame_done;
    logic [1:0]  pos, step;
    logic [3:0]  pos_mask, seen, ill_q, dp_q;
    logic [3:0]  code_q [4];
    logic [3:0]  ch_code;
    logic        ch_illegal, ch_dp;
    logic [13:0] acc, acc_next;

    sseg_char_dec u_char_dec (
        .ssegs   (ssegs),
        .code    (ch_code),
        .illegal (ch_illegal),
        .dp      (ch_dp)
    );

    always_comb begin
        pos_valid = 1'b1;
        pos       = 2'd0;
        case (disp_en)
            EN_POS3: pos = 2'd3;
            EN_POS2: pos = 2'd2;
            EN_POS1: pos = 2'd1;
            EN_POS0: pos = 2'd0;
            default: pos_valid = 1'b0;
        endcase
    end

    // A change of disp_en counts as the first stable cycle of the new dwell.
    assign cnt_eff    = (disp_en != prev_en) ? 8'd0 : stable_cnt;
    assign capture    = pos_valid && (cnt_eff == SETTLE_LAST);
    assign pos_mask   = 4'b0001 << pos;
    assign frame_done = capture && !seen[pos] && ((seen | pos_mask) == 4'hF);
    assign acc_next   = acc * 14'd10 + digit_weight(code_q[step]);
    assign out_valid  = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_en    <= 4'd0;
            stable_cnt <= 8'd0;
        end else begin
            prev_en    <= disp_en;
            stable_cnt <= (cnt_eff < SETTLE_CNT) ? cnt_eff + 8'd1 : cnt_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (frame_done) state_next = CONVERT;
            CONVERT: if (step == 2'd0) state_next = HOLD;
            HOLD:    if (out_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen    <= 4'd0;
            ill_q   <= 4'd0;
            dp_q    <= 4'd0;
            step    <= 2'd0;
            acc     <= 14'd0;
            value   <= 14'd0;
            digits  <= 16'd0;
            neg     <= 1'b0;
            no_data <= 1'b0;
            dp_en   <= 1'b0;
            dp_sel  <= 2'd0;
            err     <= 1'b0;
            for (int i = 0; i < 4; i++) code_q[i] <= 4'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (capture) begin
                        code_q[pos] <= ch_code;
                        ill_q[pos]  <= ch_illegal;
                        dp_q[pos]   <= ch_dp;
                        seen        <= seen[pos] ? pos_mask : (seen | pos_mask);
                    end
                    if (frame_done) begin
                        acc  <= 14'd0;
                        step <= 2'd3;
                    end
                end
                CONVERT: begin
                    acc  <= acc_next;
                    step <= step - 2'd1;
                    // Results are published together so they stay frozen for the whole hold.
                    if (step == 2'd0) begin
                        value   <= acc_next;
                        digits  <= {code_q[3], code_q[2], code_q[1], code_q[0]};
                        neg     <= (code_q[3] == CODE_DASH) &&
                                   ((code_q[2] <= 4'd9) || (code_q[1] <= 4'd9) || (code_q[0] <= 4'd9));
                        no_data <= (code_q[3] == CODE_DASH) && (code_q[2] == CODE_DASH) &&
                                   (code_q[1] == CODE_DASH) && (code_q[0] == CODE_DASH);
                        err     <= |ill_q;
                        dp_en   <= |dp_q;
                        dp_sel  <= dp_q[3] ? 2'd3 : dp_q[2] ? 2'd2 : dp_q[1] ? 2'd1 : 2'd0;
                    end
                end
                HOLD: begin
                    if (out_ready) seen <= 4'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef SSEG_DEC_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= 8'd0;
        else if ((state == HOLD) && capture && (pos == 2'd0) && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_sseg_frame_decode.sv
// Self-checking bench for sseg_frame_decode: directed frames plus randomized bus traffic
// compared against a frame-level reference model.
module tb_sseg_frame_decode;

    localparam int SETTLE = 4;

    logic        clk, rst;
    logic [7:0]  ssegs;
    logic [3:0]  disp_en;
    logic        out_ready, out_valid;
    logic [13:0] value;
    logic [15:0] digits;
    logic        neg, no_data, dp_en, err;
    logic [1:0]  dp_sel;
`ifdef SSEG_DEC_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    sseg_frame_decode #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .ssegs     (ssegs),
        .disp_en   (disp_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .value     (value),
        .digits    (digits),
        .neg       (neg),
        .no_data   (no_data),
        .dp_en     (dp_en),
        .dp_sel    (dp_sel),
        .err       (err)
`ifdef SSEG_DEC_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] segTab  [12] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49,
                                 8'h41, 8'h1F, 8'h01, 8'h09, 8'hFD, 8'hFF};
    logic [3:0] codeTab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};
    logic [3:0] posEn   [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] frameA  [4]  = '{8'h9F, 8'h25, 8'h0D, 8'h99};
    logic [7:0] frameB  [4]  = '{8'h49, 8'h41, 8'h1F, 8'h01};

    // Reference model: frame contents, expected result and the valid window
    logic [3:0]  lastEn;
    int          runLen, mode, doneEdge, cyc, mDrop;
    logic [3:0]  mSeen;
    logic [3:0]  mCode [4];
    bit          mIll  [4];
    bit          mDp   [4];
    int          eValue;
    logic [15:0] eDigits;
    logic        eNeg, eNoData, eDpEn, eErr;
    logic [1:0]  eDpSel;

    function automatic int pos_of(input logic [3:0] en);
        case (en)
            4'b1110: return 3;
            4'b1101: return 2;
            4'b1011: return 1;
            4'b0111: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic decode_model(input logic [7:0] s, output logic [3:0] c, output bit ill);
        logic [7:0] pat;
        pat = {s[7:1], 1'b1};
        c   = 4'hF;
        ill = 1'b1;
        for (int i = 0; i < 12; i++)
            if (pat == segTab[i]) begin
                c   = codeTab[i];
                ill = 1'b0;
            end
    endtask

    task automatic build_expected();
        int pw;
        bit anyDigit;
        eValue   = 0;
        pw       = 1;
        eDpEn    = 1'b0;
        eDpSel   = 2'd0;
        eErr     = 1'b0;
        eNoData  = 1'b1;
        anyDigit = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (mCode[p] <= 4'd9) eValue += int'(mCode[p]) * pw;
            pw *= 10;
            if (mDp[p]) begin
                eDpEn  = 1'b1;
                eDpSel = 2'(p);
            end
            if (mIll[p]) eErr = 1'b1;
            if (mCode[p] != 4'hA) eNoData = 1'b0;
            if (p < 3 && mCode[p] <= 4'd9) anyDigit = 1'b1;
        end
        eDigits = {mCode[3], mCode[2], mCode[1], mCode[0]};
        eNeg    = (mCode[3] == 4'hA) && anyDigit;
    endtask

    task automatic reset_model();
        mode   = 0;
        mSeen  = 4'd0;
        runLen = 0;
        lastEn = 4'bxxxx;
        mDrop  = 0;
    endtask

    // One clock of stimulus; the model advances on the same edge, outputs are sampled 1 ns later
    task automatic tick(input logic [3:0] en, input logic [7:0] seg, input logic rdy);
        int p, e;
        bit cap, il;
        logic [3:0] c;
        disp_en   = en;
        ssegs     = seg;
        out_ready = rdy;
        runLen    = (en === lastEn) ? runLen + 1 : 1;
        lastEn    = en;
        p   = pos_of(en);
        cap = (p >= 0) && (runLen == SETTLE);
        e   = cyc + 1;
        if (mode == 0) begin
            if (cap) begin
                decode_model(seg, c, il);
                mCode[p] = c;
                mIll[p]  = il;
                mDp[p]   = !seg[0];
                mSeen    = mSeen[p] ? (4'b0001 << p) : (mSeen | (4'b0001 << p));
                if (mSeen == 4'hF) begin
                    mode     = 1;
                    doneEdge = e;
                    build_expected();
                end
            end
        end else if (mode == 1) begin
            if (e - doneEdge == 4) mode = 2;
        end else begin
            if (cap && p == 0 && mDrop < 255) mDrop++;
            if (rdy) begin
                mode  = 0;
                mSeen = 4'd0;
            end
        end
        @(posedge clk);
        cyc = e;
        #1;
    endtask

    task automatic dwell(input logic [3:0] en, input logic [7:0] seg, input int len, input logic rdy);
        for (int i = 0; i < len; i++) tick(en, seg, rdy);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        disp_en   = 4'b1111;
        ssegs     = 8'hFF;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid, value, digits, neg, no_data, dp_en, dp_sel, err} !== 39'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {out_valid, value, digits, neg, no_data, dp_en, dp_sel, err});
        end
`ifdef SSEG_DEC_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_drop_cnt got=%0d want=0", drop_cnt);
        end
`endif
    endtask

    // Scan one frame with out_ready high, then check the single-cycle result pulse
    task automatic test_frame(input string nm, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0, input bit glitch,
                              input int wantVal, input logic [15:0] wantDig, input logic [5:0] wantFlags);
        int pulses;
        logic [13:0] gotVal;
        logic [15:0] gotDig;
        logic [5:0]  gotFlags;
        pulses = 0;
        dwell(4'b1110, s3, SETTLE + 2, 1'b1);
        if (glitch) begin
            dwell(4'b1111, 8'hFF, SETTLE, 1'b1);
            dwell(4'b0011, 8'h01, SETTLE, 1'b1);
        end
        dwell(4'b1101, s2, SETTLE + 2, 1'b1);
        dwell(4'b1011, s1, SETTLE + 2, 1'b1);
        if (glitch) begin
            dwell(4'b0111, 8'h01, SETTLE - 1, 1'b1);
            dwell(4'b1111, 8'hFF, 2, 1'b1);
        end
        dwell(4'b0111, s0, SETTLE + 2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(4'b1111, 8'hFF, 1'b1);
            total++;
            if (out_valid !== (mode == 2)) begin
                bad++;
                $display("[TB] FAIL %s_valid cyc=%0d got=%b want=%b", nm, cyc, out_valid, mode == 2);
            end
            if (out_valid === 1'b1) begin
                pulses++;
                gotVal   = value;
                gotDig   = digits;
                gotFlags = {neg, no_data, dp_en, dp_sel, err};
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("[TB] FAIL %s_pulses got=%0d want=1", nm, pulses);
        end
        total++;
        if ({gotVal, gotDig, gotFlags} !== {wantVal[13:0], wantDig, wantFlags}) begin
            bad++;
            $display("[TB] FAIL %s_result got v=%0d d=%h f=%b want v=%0d d=%h f=%b",
                     nm, gotVal, gotDig, gotFlags, wantVal, wantDig, wantFlags);
        end
        total++;
        if ({gotVal, gotDig, gotFlags} !== {eValue[13:0], eDigits, eNeg, eNoData, eDpEn, eDpSel, eErr}) begin
            bad++;
            $display("[TB] FAIL %s_model got v=%0d d=%h f=%b want v=%0d d=%h f=%b", nm, gotVal, gotDig,
                     gotFlags, eValue, eDigits, {eNeg, eNoData, eDpEn, eDpSel, eErr});
        end
    endtask

    task automatic test_hold();
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < SETTLE + 2; c++) begin
                    tick(posEn[3 - k], (f == 0) ? frameA[k] : frameB[k], 1'b0);
                    total++;
                    if (out_valid !== (mode == 2)) begin
                        bad++;
                        $display("[TB] FAIL hold_valid cyc=%0d got=%b want=%b", cyc, out_valid, mode == 2);
                    end
                    if (out_valid === 1'b1) begin
                        total++;
                        if (value !== 14'd1234 || digits !== 16'h1234) begin
                            bad++;
                            $display("[TB] FAIL hold_frozen got v=%0d d=%h want v=1234 d=1234", value, digits);
                        end
                    end
                end
`ifdef SSEG_DEC_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd3) begin
            bad++;
            $display("[TB] FAIL hold_drop_cnt got=%0d want=3", drop_cnt);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            tick(4'b1111, 8'hFF, 1'b1);
            total++;
            if (out_valid !== (mode == 2)) begin
                bad++;
                $display("[TB] FAIL hold_release cyc=%0d got=%b want=%b", cyc, out_valid, mode == 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) dwell(posEn[3 - k], frameA[k], SETTLE + 2, 1'b1);
        dwell(4'b0111, frameA[3], SETTLE, 1'b1);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, value, digits, neg, no_data, dp_en, dp_sel, err} !== 39'd0) begin
            bad++;
            $display("[TB] FAIL reset_in_convert got=%h want=0",
                     {out_valid, value, digits, neg, no_data, dp_en, dp_sel, err});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_model();

        for (int k = 0; k < 4; k++) dwell(posEn[3 - k], frameB[k], SETTLE + 2, 1'b0);
        for (int i = 0; i < 10; i++)
            if (mode != 2) tick(4'b1111, 8'hFF, 1'b0);
        total++;
        if (out_valid !== 1'b1 || value !== 14'd5678) begin
            bad++;
            $display("[TB] FAIL hold_entry got valid=%b v=%0d want valid=1 v=5678", out_valid, value);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, value, digits, neg, no_data, dp_en, dp_sel, err} !== 39'd0) begin
            bad++;
            $display("[TB] FAIL reset_in_hold got=%h want=0",
                     {out_valid, value, digits, neg, no_data, dp_en, dp_sel, err});
        end
`ifdef SSEG_DEC_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_in_hold_drop got=%0d want=0", drop_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
    endtask

    task automatic test_random();
        int scanPos, len, r, frames;
        logic [3:0] en;
        logic [7:0] seg, base;
        logic rdy;
        scanPos = 3;
        frames  = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                en      = posEn[scanPos];
                scanPos = (scanPos + 3) % 4;
            end else if (r == 7) en = posEn[$urandom_range(0, 3)];
            else if (r == 8)     en = 4'b1111;
            else                 en = 4'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                base = segTab[$urandom_range(0, 11)];
                seg  = {base[7:1], ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1};
            end else begin
                seg = 8'($urandom);
            end
            len = $urandom_range(1, SETTLE + 3);
            rdy = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < len; c++) begin
                tick(en, seg, rdy);
                total++;
                if (out_valid !== (mode == 2)) begin
                    bad++;
                    $display("[TB] FAIL rand_valid cyc=%0d got=%b want=%b", cyc, out_valid, mode == 2);
                end
                if (out_valid === 1'b1) begin
                    frames++;
                    total++;
                    if ({value, digits, neg, no_data, dp_en, dp_sel, err} !==
                        {eValue[13:0], eDigits, eNeg, eNoData, eDpEn, eDpSel, eErr}) begin
                        bad++;
                        $display("[TB] FAIL rand_frame cyc=%0d got v=%0d d=%h f=%b want v=%0d d=%h f=%b",
                                 cyc, value, digits, {neg, no_data, dp_en, dp_sel, err},
                                 eValue, eDigits, {eNeg, eNoData, eDpEn, eDpSel, eErr});
                    end
                end
`ifdef SSEG_DEC_DROP_CNT_EN
                total++;
                if (drop_cnt !== 8'(mDrop)) begin
                    bad++;
                    $display("[TB] FAIL rand_drop_cnt cyc=%0d got=%0d want=%0d", cyc, drop_cnt, mDrop);
                end
`endif
            end
        end
        $display("[TB] random traffic produced %0d valid cycles", frames);
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        reset_model();
        test_reset();
        test_frame("basic_1234", 8'h9F, 8'h25, 8'h0D, 8'h99, 1'b0, 1234, 16'h1234, 6'b000000);
        test_frame("blank_lead", 8'hFF, 8'hFF, 8'hFF, 8'h01, 1'b0, 8, 16'hFFF8, 6'b000000);
        test_frame("negative", 8'hFD, 8'hFF, 8'h9F, 8'h25, 1'b0, 12, 16'hAF12, 6'b100000);
        test_frame("no_data", 8'hFD, 8'hFD, 8'hFD, 8'hFD, 1'b0, 0, 16'hAAAA, 6'b010000);
        test_frame("dp_tens", 8'hFF, 8'hFF, 8'h40, 8'hFF, 1'b0, 60, 16'hFF6F, 6'b001010);
        test_frame("illegal", 8'h9F, 8'h55, 8'h25, 8'h0D, 1'b0, 1023, 16'h1F23, 6'b000001);
        test_frame("glitch", 8'h9F, 8'h25, 8'h0D, 8'h99, 1'b1, 1234, 16'h1234, 6'b000000);
        test_hold();
        test_reset_mid();
        test_frame("after_reset", 8'h99, 8'h0D, 8'h25, 8'h9F, 1'b0, 4321, 16'h4321, 6'b000000);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
